// File: rtl/vga_frame_shadow.sv
// vga_frame_shadow
//   Double-buffered game-state bank feeding the VGA controller. The game
//   processor writes a staging bank at any time and requests a commit. The
//   staging bank is copied to the active (output) bank only at the start of
//   vertical sync, so a frame never mixes old and new piece positions.
//   A free-running frame counter is kept for timing and debug.
//
// Ports
//   iVGA_CLK        pixel clock
//   iRST_n          asynchronous active-low reset
//   iVS             vertical sync (controller's registered oVS)
//   wr_en           staging write strobe
//   wr_addr         staging register index (0..10 mapped)
//   wr_data         staging write data
//   commit_req      single-cycle request to publish staging at next frame start
//   rd_addr         staging readback index
//   rd_data         combinational staging readback, 0 for unmapped indices
//   commit_pending  a commit waits for the next frame start
//   commit_done     one-cycle pulse in the cycle after the copy
//   frame_count     frame starts since reset, wraps
//   block1x..score, blockType, screenMode   active bank outputs
module vga_frame_shadow #(
   parameter bit          VS_ACTIVE_LOW = 1'b1,
   parameter int unsigned FRAME_CNT_W   = 16
) (
   input  logic                   iVGA_CLK,
   input  logic                   iRST_n,
   input  logic                   iVS,
   input  logic                   wr_en,
   input  logic [3:0]             wr_addr,
   input  logic [31:0]            wr_data,
   input  logic                   commit_req,
   input  logic [3:0]             rd_addr,
   output logic [31:0]            rd_data,
   output logic                   commit_pending,
   output logic                   commit_done,
   output logic [FRAME_CNT_W-1:0] frame_count,
   output logic [31:0]            block1x,
   output logic [31:0]            block1y,
   output logic [31:0]            block2x,
   output logic [31:0]            block2y,
   output logic [31:0]            block3x,
   output logic [31:0]            block3y,
   output logic [31:0]            block4x,
   output logic [31:0]            block4y,
   output logic [31:0]            score,
   output logic [31:0]            blockType,
   output logic [31:0]            screenMode
);

   localparam int unsigned NUM_REGS = 11;
   localparam logic [3:0]  LAST_ADDR = 4'd10;
   localparam logic        VS_ACTIVE = VS_ACTIVE_LOW ? 1'b0 : 1'b1;
   localparam logic        VS_IDLE   = ~VS_ACTIVE;

   logic [31:0]            staging_q [NUM_REGS];
   logic [31:0]            active_q  [NUM_REGS];
   logic                   vs_d;
   logic                   pending_q;
   logic                   done_q;
   logic [FRAME_CNT_W-1:0] frame_q;

   logic fs;
   logic do_copy;

   // Frame start: sync goes from idle to active level.
   assign fs      = (vs_d == VS_IDLE) && (iVS == VS_ACTIVE);
   assign do_copy = fs && pending_q;

   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            staging_q[i] <= '0;
            active_q[i]  <= '0;
         end
         vs_d      <= VS_IDLE;
         pending_q <= 1'b0;
         done_q    <= 1'b0;
         frame_q   <= '0;
      end else begin
         vs_d   <= iVS;
         done_q <= do_copy;
         if (fs) begin
            frame_q <= frame_q + FRAME_CNT_W'(1);
         end
         // Non-blocking copy reads staging before any write on this same edge.
         if (do_copy) begin
            for (int i = 0; i < NUM_REGS; i++) begin
               active_q[i] <= staging_q[i];
            end
         end
         if (wr_en && (wr_addr <= LAST_ADDR)) begin
            staging_q[wr_addr] <= wr_data;
         end
         // A request on the copy edge re-arms for the following frame.
         if (commit_req) begin
            pending_q <= 1'b1;
         end else if (do_copy) begin
            pending_q <= 1'b0;
         end
      end
   end

   always_comb begin
      rd_data = '0;
      if (rd_addr <= LAST_ADDR) begin
         rd_data = staging_q[rd_addr];
      end
   end

   assign commit_pending = pending_q;
   assign commit_done    = done_q;
   assign frame_count    = frame_q;

   assign block1x    = active_q[0];
   assign block1y    = active_q[1];
   assign block2x    = active_q[2];
   assign block2y    = active_q[3];
   assign block3x    = active_q[4];
   assign block3y    = active_q[5];
   assign block4x    = active_q[6];
   assign block4y    = active_q[7];
   assign score      = active_q[8];
   assign blockType  = active_q[9];
   assign screenMode = active_q[10];

endmodule

// File: doc/vga_frame_shadow.md
Name: vga_frame_shadow

Overview:
- Double-buffered game-state register bank that sits directly upstream of the VGA controller and drives its block1x..block4y, score, blockType and screenMode inputs.
- The game processor writes a staging bank at any time and requests a commit.
- The staging bank is copied to the active (output) bank only at the start of vertical sync, so a frame never mixes old and new piece positions (no tearing).
- Also keeps a frame counter for timing and debug.

Parameters:
- VS_ACTIVE_LOW, 1, polarity of iVS; 1 means the sync pulse is low (falling edge = frame start).
- FRAME_CNT_W, 16, width of frame_count.

Ports:
- iVGA_CLK  in  1  pixel clock.
- iRST_n  in  1  asynchronous, active-low reset.
- iVS  in  1  vertical sync, taken from the controller's registered oVS.
- wr_en  in  1  staging write strobe, one write per cycle.
- wr_addr  in  4  staging register index.
- wr_data  in  32  staging write data.
- commit_req  in  1  single-cycle request to publish the staging bank.
- rd_addr  in  4  staging readback index.
- rd_data  out  32  combinational staging readback; 0 for unmapped indices.
- commit_pending  out  1  a commit is waiting for the next frame start.
- commit_done  out  1  one-cycle pulse in the cycle after the copy.
- frame_count  out  FRAME_CNT_W  frames since reset; wraps.
- block1x, block1y, block2x, block2y, block3x, block3y, block4x, block4y  out  32 each  active bank.
- score, blockType, screenMode  out  32 each  active bank.

Behaviour:
- Register map, same for staging and active banks:
  - 0 block1x, 1 block1y, 2 block2x, 3 block2y, 4 block3x, 5 block3y, 6 block4x, 7 block4y
  - 8 score, 9 blockType, 10 screenMode
  - 11..15 unmapped: writes ignored, rd_data 0
- Reset (async assert, sync release on iVGA_CLK): both banks 0, commit_pending 0, commit_done 0, frame_count 0, vs_d = inactive level.
  - screenMode = 0 selects controller mode 0 (full-screen image).
- Staging write: on a rising edge with wr_en=1 and wr_addr<=10, staging[wr_addr] <= wr_data. Readable on rd_data the next cycle.
- Frame-start detect:
  - vs_d registers iVS every cycle.
  - fs = (vs_d==inactive) && (iVS==active); for VS_ACTIVE_LOW=1 this is vs_d==1 && iVS==0.
  - fs is asserted for exactly one cycle per frame.
- On every fs edge, frame_count <= frame_count+1, modulo 2^FRAME_CNT_W.
- commit_pending:
  - Set at the edge where commit_req=1.
  - Cleared at the edge where fs=1 and the copy occurs.
- Copy:
  - At the edge where fs=1 and commit_pending=1, all 11 active regs <= staging.
  - Outputs change in the cycle after that edge.
  - commit_done = 1 for exactly that following cycle.
- No commit pending at fs: active bank holds; commit_done stays 0.
- Simultaneous events at the copy edge:
  - wr_en=1 at the copy edge: the copy uses the pre-write staging value. The write lands in staging only and goes out with a later commit.
  - commit_req=1 at the copy edge: the copy proceeds and commit_pending stays 1 (re-armed for the next frame).
  - commit_req=1 while already pending: no effect (requests coalesce).
- Writes while pending are allowed. Any write accepted before the copy edge is included in the copy.
- A mid-frame reset returns every output to its reset value immediately; a pending commit is discarded.
- The only state is the two 11x32 banks, vs_d, the pending flag, the done flag and the counter. No other latency.

Test Plan:
- Reset with iVS high → all outputs 0, commit_pending 0, frame_count 0.
- Write block1x=5 and screenMode=32'h2000_0000, pulse commit_req, then drive iVS 1→0 → block1x stays 0 until the edge after the fall. Then block1x=5, screenMode[31:29]=1, commit_done high for exactly 1 cycle, commit_pending 0.
- Write score=100, no commit, run 3 frames → score output stays 0. frame_count advances by 3, and only on iVS falling edges, not on rising edges or while held low.
- At the copy edge, write block2y=7 (staging block2y was 3) with commit_req high → active block2y=3, commit_pending stays 1. After the next fall, block2y=7.
- Write wr_addr=12 with data 32'hDEAD → rd_data(12)=0, no active register changes after a commit.
- Set commit_pending, then pulse iRST_n low mid-frame → all outputs 0 asynchronously. The next frame start commits nothing. Separately, preload frame_count to 16'hFFFF and give one more frame start → frame_count wraps to 0.
